// File: rtl/flow_match_pkg.sv
// -----------------------------------------------------------------------------
// flow_match_pkg
// Shared types and default constants for the flow-key lookup stage.
//   - state_t  : lookup FSM encoding (IDLE, SCAN, RESP)
//   - KEY_W_DEF / DEPTH_DEF : default key width and table depth
//   - entry_t  : one table entry {vld, key} at the default key width. The
//                matcher rebuilds the same layout at its own KEY_W so that a
//                non-default width stays self-consistent.
// -----------------------------------------------------------------------------
package flow_match_pkg;

    localparam int unsigned KEY_W_DEF = 32'd8;
    localparam int unsigned DEPTH_DEF = 32'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                 vld;
        logic [KEY_W_DEF-1:0] key;
    } entry_t;

endpackage : flow_match_pkg

// File: rtl/key_eq_comp.sv
// -----------------------------------------------------------------------------
// key_eq_comp
// Purely combinational KEY_W-bit equality comparator.
// Ports:
//   i_a, i_b : operands
//   o_eq     : 1 when i_a == i_b
// -----------------------------------------------------------------------------
module key_eq_comp #(
    parameter int unsigned KEY_W = 32'd8
) (
    input  logic [KEY_W-1:0] i_a,
    input  logic [KEY_W-1:0] i_b,
    output logic             o_eq
);

    // Any differing bit clears the result.
    assign o_eq = ~(|(i_a ^ i_b));

endmodule : key_eq_comp

// File: rtl/flow_key_matcher.sv
// -----------------------------------------------------------------------------
// flow_key_matcher
// Sequential exact-match lookup over a small programmable key table. A request
// key is captured, then the table is scanned one entry per cycle (lowest index
// first) through a single equality comparator. The first valid matching entry
// ends the scan with a hit; running off the last entry ends it with a miss.
// The result is held on a valid/ready handshake until taken downstream.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   wr_en/wr_idx/wr_key/wr_vld : table write port (any state, effective next cycle)
//   req_valid/req_ready/req_key : lookup request handshake
//   rsp_valid/rsp_ready/rsp_hit/rsp_idx : lookup result handshake
//
// All outputs come straight from registers; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module flow_key_matcher
    import flow_match_pkg::*;
#(
    parameter  int unsigned KEY_W = KEY_W_DEF,
    parameter  int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [KEY_W-1:0] wr_key,
    input  logic             wr_vld,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [KEY_W-1:0] req_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [IDX_W-1:0] rsp_idx
);

    // Same layout as flow_match_pkg::entry_t, sized to this instance's KEY_W.
    typedef struct packed {
        logic             vld;
        logic [KEY_W-1:0] key;
    } tbl_entry_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 32'd1);

    state_t           r_state;
    state_t           w_next_state;
    logic [KEY_W-1:0] r_key;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    tbl_entry_t       r_tbl [DEPTH];

    logic             r_req_ready;
    logic             r_rsp_valid;
    logic             r_rsp_hit;
    logic [IDX_W-1:0] r_rsp_idx;

    logic             w_accept;
    logic             w_key_eq;
    logic             w_match;
    logic             w_last;
    logic             w_load_rsp;
    logic             w_hit_nxt;
    logic [IDX_W-1:0] w_idx_nxt;

    // req_ready is itself a register that is only high in IDLE, so accepting
    // needs no state decode here.
    assign w_accept = req_valid & r_req_ready;
    assign w_last   = (r_ptr == LAST_IDX);

    key_eq_comp #(
        .KEY_W (KEY_W)
    ) u_key_eq_comp (
        .i_a  (r_key),
        .i_b  (r_tbl[r_ptr].key),
        .o_eq (w_key_eq)
    );

    // An entry only matches while its valid bit is set.
    assign w_match = w_key_eq & r_tbl[r_ptr].vld;

    // Next-state, scan pointer and result-load decode.
    always_comb begin
        w_next_state = r_state;
        w_ptr_nxt    = r_ptr;
        w_load_rsp   = 1'b0;
        w_hit_nxt    = 1'b0;
        w_idx_nxt    = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SCAN;
                    w_ptr_nxt    = '0;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SCAN: begin
                if (w_match) begin
                    // Scan order makes the lowest matching index win.
                    w_next_state = RESP;
                    w_load_rsp   = 1'b1;
                    w_hit_nxt    = 1'b1;
                    w_idx_nxt    = r_ptr;
                end else if (w_last) begin
                    w_next_state = RESP;
                    w_load_rsp   = 1'b1;
                    w_hit_nxt    = 1'b0;
                    w_idx_nxt    = '0;
                end else begin
                    w_ptr_nxt    = r_ptr + IDX_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RESP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // FSM state, scan pointer and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_idx   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_ptr       <= w_ptr_nxt;
            // Decoding the next state keeps both flags aligned with r_state
            // while still being plain flops at the outputs.
            r_req_ready <= (w_next_state == IDLE);
            r_rsp_valid <= (w_next_state == RESP);
            if (w_load_rsp) begin
                r_rsp_hit <= w_hit_nxt;
                r_rsp_idx <= w_idx_nxt;
            end
        end
    end

    // Lookup key capture on the accept cycle; contents are don't-care otherwise.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_key <= req_key;
        end
    end

    // Key table: reset clears valid bits only; a write lands at the clock edge,
    // so a compare in the same cycle still sees the previous contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_tbl[i].vld <= 1'b0;
            end
        end else if (wr_en) begin
            r_tbl[wr_idx].vld <= wr_vld;
            r_tbl[wr_idx].key <= wr_key;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_idx   = r_rsp_idx;

endmodule : flow_key_matcher

// File: doc/flow_key_matcher.md
# flow_key_matcher

Sequential exact-match lookup stage that feeds the equality comparator and consumes its result. It holds a small programmable table of flow keys, accepts one lookup key per request, and scans the table one entry per cycle through a W-bit equality comparator. It returns hit/miss plus the matching index to the downstream action stage over a valid/ready handshake.

## Interface
- KEY_W, 8: width of a flow key in bits (≥1).
- DEPTH, 8: number of table entries (power of two, ≥2).
- IDX_W, $clog2(DEPTH): entry index width (derived, not overridden).

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  table write strobe.
- wr_idx  in  IDX_W  entry to write.
- wr_key  in  KEY_W  key value to store.
- wr_vld  in  1  entry-valid bit to store (0 = invalidate entry).
- req_valid  in  1  lookup request present.
- req_ready  out  1  matcher can accept a request.
- req_key  in  KEY_W  key to look up; sampled only on the accept cycle.
- rsp_valid  out  1  lookup result present.
- rsp_ready  in  1  downstream accepts result.
- rsp_hit  out  1  1 = key found in a valid entry.
- rsp_idx  out  IDX_W  index of the matching entry; 0 on miss.

## Operation
- FSM states: IDLE, SCAN, RESP.
- IDLE: req_ready=1. On req_valid, the request is accepted: req_key is captured in a key register, the scan pointer is set to 0, and the FSM moves to SCAN.
- SCAN: req_ready=0. Each cycle, entry[ptr] is compared with the captured key.
  - Entry valid and keys equal: set hit=1, set idx=ptr, move to RESP.
  - Otherwise, if ptr==DEPTH-1: set hit=0, set idx=0, move to RESP.
  - Otherwise: ptr increments.
- RESP: rsp_valid=1 and rsp_hit/rsp_idx are stable. On rsp_ready, the FSM returns to IDLE. Results are held indefinitely under backpressure.
- Multiple matching entries: the lowest index wins, as a consequence of the scan order.
- Table writes are accepted in any state and take effect on the next cycle. A SCAN compare in the same cycle as a write to that entry uses the old contents.
- Reset: all entry valid bits cleared, FSM to IDLE, ptr=0, rsp_valid=0, rsp_hit=0, rsp_idx=0. req_ready is 0 during reset and 1 in the first cycle after. Key storage need not be cleared.
- Reset asserted mid-SCAN or in RESP: the lookup is aborted and no response is produced.

## Timing
- Request accepted at cycle T (req_valid & req_ready):
  - Entry k is compared at cycle T+1+k.
  - A hit at entry k gives rsp_valid high from cycle T+2+k.
  - A miss gives rsp_valid high from cycle T+1+DEPTH.
- Response handshake completes at cycle R (rsp_valid & rsp_ready). req_ready is high from R+1, so there is no same-cycle turnaround and the minimum period per lookup is k+3 cycles.
- All outputs are driven directly by registers or FSM state. There is no combinational path from any input to any output.

## Structure
- Shared package flow_match_pkg:
  - FSM state enum (IDLE, SCAN, RESP).
  - Default KEY_W/DEPTH constants.
  - The table entry struct {vld, key}.
- Sub-module key_eq_comp, parameterised on KEY_W: purely combinational bitwise equality, with a 1 output when a==b. It is instantiated once and fed the captured key and entry[ptr].key. The matcher ANDs its output with entry[ptr].vld.
- Table is a register array of DEPTH entries (no RAM macro).

## Test plan
- Reset, then a lookup of 0x5A on the empty table: response is a miss with rsp_hit=0, rsp_idx=0, rsp_valid rising at T+9 (DEPTH=8).
- Write entry 3=0x5A valid, then look up 0x5A: rsp_hit=1, rsp_idx=3, rsp_valid rising at T+5.
- Entries 2 and 6 both 0x11 valid, look up 0x11: rsp_idx=2. Then invalidate entry 2 and repeat: rsp_idx=6.
- Hold rsp_ready=0 for 10 cycles during RESP: rsp_valid/rsp_hit/rsp_idx stay stable and req_ready stays 0. When rsp_ready is raised, req_ready=1 on the next cycle.
- Look up 0x33 with entry 4 holding 0x22; write entry 4=0x33 in the cycle entry 4 is compared: result is a miss. An immediate repeat lookup gives a hit at idx 4.
- Assert rst during SCAN at ptr=2: no rsp_valid pulse occurs, all entries read invalid, and req_ready=1 on the first cycle after reset.
